operand_stream_loader: RTL and testbench

- Upstream stage of the BRAM-backed floating-point multiply system.
- Accepts a valid/ready stream of 8-bit operand pairs and packs each pair into one BRAM word.
- Writes the words through the system's external BRAM port, then runs the compute pass with start and waits for done.
- Reports completion, word count, and error flags to the host sequencer.

---
 rtl/operand_stream_loader.sv | 149 ++++++++++++++
 tb/tb_operand_stream_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stream_loader.sv
// Loads a valid/ready stream of operand pairs into BRAM through the system's
// external port, then runs the compute pass and reports completion and errors.
module operand_stream_loader #(
  parameter int AWIDTH    = 9,
  parameter int DWIDTH    = 40,
  parameter int CWIDTH    = 8,
  parameter int MAX_WORDS = 512,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_go,
  input  logic [AWIDTH-1:0] cfg_base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CWIDTH-1:0] in_a,
  input  logic [CWIDTH-1:0] in_b,
  input  logic              in_last,
  output logic              ext_external,
  output logic              ext_bram_sel,
  output logic [AWIDTH-1:0] ext_addr,
  output logic [DWIDTH-1:0] ext_wdata,
  output logic              ext_wren,
  output logic              sys_start,
  input  logic              sys_done,
  output logic              busy,
  output logic [AWIDTH:0]   load_count,
  output logic              run_done,
  output logic              overflow,
  output logic              timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PAD  = DWIDTH - 2 * CWIDTH;

  localparam logic [AWIDTH:0]   MAX_CNT = (AWIDTH + 1)'(MAX_WORDS);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [AWIDTH-1:0] base;
  logic [WD_W-1:0]   watchdog;
  logic              accept;
  logic [AWIDTH:0]   count_inc;

  assign accept    = (state == S_LOAD) && in_valid && in_ready;
  assign count_inc = load_count + (AWIDTH + 1)'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      base         <= '0;
      watchdog     <= '0;
      in_ready     <= 1'b0;
      ext_external <= 1'b0;
      ext_bram_sel <= 1'b0;
      ext_addr     <= '0;
      ext_wdata    <= '0;
      ext_wren     <= 1'b0;
      sys_start    <= 1'b0;
      busy         <= 1'b0;
      load_count   <= '0;
      run_done     <= 1'b0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      ext_wren <= 1'b0;
      run_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_go) begin
            base         <= cfg_base_addr;
            load_count   <= '0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            state        <= S_LOAD;
            busy         <= 1'b1;
            in_ready     <= (MAX_CNT != '0);
            ext_external <= 1'b1;
            ext_bram_sel <= 1'b1;
          end
        end

        S_LOAD: begin
          if (accept) begin
            ext_wren   <= 1'b1;
            ext_addr   <= base + load_count[AWIDTH-1:0];
            ext_wdata  <= {{PAD{1'b0}}, in_b, in_a};
            load_count <= count_inc;
            if (in_last) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end else if (count_inc == MAX_CNT) begin
              overflow <= 1'b1;
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end

        // The last write is still on the port this cycle, so the port stays
        // claimed until the run begins.
        S_FLUSH: begin
          state        <= S_RUN;
          ext_external <= 1'b0;
          ext_bram_sel <= 1'b0;
          sys_start    <= 1'b1;
          watchdog     <= '0;
        end

        // sys_done is tested first so it wins over a coincident watchdog expiry.
        S_RUN: begin
          if (sys_done) begin
            state     <= S_FINISH;
            sys_start <= 1'b0;
            run_done  <= 1'b1;
          end else if (watchdog == WD_LAST) begin
            state     <= S_FINISH;
            sys_start <= 1'b0;
            run_done  <= 1'b1;
            timeout   <= 1'b1;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state        <= S_IDLE;
          busy         <= 1'b0;
          in_ready     <= 1'b0;
          ext_external <= 1'b0;
          ext_bram_sel <= 1'b0;
          sys_start    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_stream_loader.sv
// Directed bench for operand_stream_loader with MAX_WORDS=4 and TIMEOUT=16.
module tb_operand_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_go;
  logic [8:0]  cfg_base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        ext_external;
  logic        ext_bram_sel;
  logic [8:0]  ext_addr;
  logic [39:0] ext_wdata;
  logic        ext_wren;
  logic        sys_start;
  logic        sys_done;
  logic        busy;
  logic [9:0]  load_count;
  logic        run_done;
  logic        overflow;
  logic        timeout;

  int vectors     = 0;
  int miscompares = 0;

  operand_stream_loader #(
    .AWIDTH(9),
    .DWIDTH(40),
    .CWIDTH(8),
    .MAX_WORDS(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_go(cfg_go),
    .cfg_base_addr(cfg_base_addr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_last(in_last),
    .ext_external(ext_external),
    .ext_bram_sel(ext_bram_sel),
    .ext_addr(ext_addr),
    .ext_wdata(ext_wdata),
    .ext_wren(ext_wren),
    .sys_start(sys_start),
    .sys_done(sys_done),
    .busy(busy),
    .load_count(load_count),
    .run_done(run_done),
    .overflow(overflow),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [8:0] base);
    cfg_base_addr = base;
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    chk("go_in_ready", 64'(in_ready), 64'(1));
    chk("go_load_count", 64'(load_count), 64'(0));
  endtask

  task automatic finish_run();
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    chk("tail_sys_start", 64'(sys_start), 64'(1));
    sys_done = 1'b1;
    tick();
    chk("tail_run_done", 64'(run_done), 64'(1));
    sys_done = 1'b0;
    tick();
    chk("tail_busy", 64'(busy), 64'(0));
  endtask

  logic [39:0] exp_w [4];
  logic [8:0]  wrap_a [3];
  logic [4:0]  pat;
  int          n;

  initial begin
    exp_w  = '{40'h0000000201, 40'h0000000403, 40'h0000000605, 40'h0000000807};
    wrap_a = '{9'h1FE, 9'h1FF, 9'h000};
    pat    = 5'b11001;

    reset = 1'b0; cfg_go = 1'b0; cfg_base_addr = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; sys_done = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ext_external", 64'(ext_external), 64'(0));
    chk("rst_wren", 64'(ext_wren), 64'(0));
    chk("rst_sys_start", 64'(sys_start), 64'(0));
    chk("rst_load_count", 64'(load_count), 64'(0));
    reset = 1'b1;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'(0));

    // basic load and run
    start_run(9'h010);
    chk("t1_ext_external", 64'(ext_external), 64'(1));
    chk("t1_bram_sel", 64'(ext_bram_sel), 64'(1));
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a = 8'(2 * i + 1);
      in_b = 8'(2 * i + 2);
      in_last = (i == 3);
      tick();
      chk("t1_wren", 64'(ext_wren), 64'(1));
      chk("t1_addr", 64'(ext_addr), 64'(16 + i));
      chk("t1_wdata", 64'(ext_wdata), 64'(exp_w[i]));
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1_load_count", 64'(load_count), 64'(4));
    chk("t1_flush_in_ready", 64'(in_ready), 64'(0));
    chk("t1_flush_external", 64'(ext_external), 64'(1));
    chk("t1_flush_start", 64'(sys_start), 64'(0));
    tick();
    chk("t1_sys_start", 64'(sys_start), 64'(1));
    chk("t1_run_external", 64'(ext_external), 64'(0));
    chk("t1_run_wren", 64'(ext_wren), 64'(0));
    sys_done = 1'b1;
    tick();
    sys_done = 1'b0;
    chk("t1_run_done", 64'(run_done), 64'(1));
    chk("t1_finish_start", 64'(sys_start), 64'(0));
    chk("t1_finish_busy", 64'(busy), 64'(1));
    tick();
    chk("t1_run_done_pulse", 64'(run_done), 64'(0));
    chk("t1_idle_busy", 64'(busy), 64'(0));
    chk("t1_count_hold", 64'(load_count), 64'(4));
    chk("t1_overflow", 64'(overflow), 64'(0));

    // backpressure gaps
    start_run(9'h040);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i];
      in_a = 8'(8'h10 + i);
      in_b = 8'(8'h20 + i);
      in_last = (i == 4);
      tick();
      chk("t2_wren", 64'(ext_wren), 64'(pat[i]));
      if (pat[i]) begin
        chk("t2_addr", 64'(ext_addr), 64'(32'h40 + n));
        n++;
      end
    end
    chk("t2_writes", 64'(n), 64'(3));
    chk("t2_load_count", 64'(load_count), 64'(3));
    finish_run();

    // address wrap
    start_run(9'h1FE);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = 8'(i);
      in_b = 8'(i);
      in_last = (i == 2);
      tick();
      chk("t3_addr", 64'(ext_addr), 64'(wrap_a[i]));
    end
    chk("t3_load_count", 64'(load_count), 64'(3));
    finish_run();

    // overflow: 6 beats offered, MAX_WORDS is 4
    start_run(9'h080);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a = 8'(i);
      in_b = 8'(i);
      in_last = 1'b0;
      tick();
      chk("t4_wren", 64'(ext_wren), 64'(i < 4));
      chk("t4_in_ready", 64'(in_ready), 64'(i < 3));
      if (i == 3) begin
        chk("t4_overflow", 64'(overflow), 64'(1));
        chk("t4_load_count", 64'(load_count), 64'(4));
      end
      if (i == 4)
        chk("t4_sys_start", 64'(sys_start), 64'(1));
    end
    in_valid = 1'b0;
    sys_done = 1'b1;
    tick();
    sys_done = 1'b0;
    chk("t4_run_done", 64'(run_done), 64'(1));
    tick();
    chk("t4_overflow_hold", 64'(overflow), 64'(1));
    chk("t4_idle_busy", 64'(busy), 64'(0));

    // timeout with an ignored cfg_go during RUN
    start_run(9'h0A0);
    chk("t5_overflow_clr", 64'(overflow), 64'(0));
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'hAA; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    cfg_base_addr = 9'h1AA;
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    chk("t5_go_ignored_busy", 64'(busy), 64'(1));
    chk("t5_go_ignored_start", 64'(sys_start), 64'(1));
    repeat (14) tick();
    chk("t5_last_run_start", 64'(sys_start), 64'(1));
    chk("t5_last_run_timeout", 64'(timeout), 64'(0));
    tick();
    chk("t5_timeout", 64'(timeout), 64'(1));
    chk("t5_run_done", 64'(run_done), 64'(1));
    chk("t5_sys_start", 64'(sys_start), 64'(0));
    tick();
    chk("t5_idle_busy", 64'(busy), 64'(0));
    chk("t5_timeout_hold", 64'(timeout), 64'(1));
    chk("t5_count_hold", 64'(load_count), 64'(1));

    // sys_done coinciding with the watchdog limit
    start_run(9'h000);
    chk("t6_timeout_clr", 64'(timeout), 64'(0));
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    repeat (15) tick();
    chk("t6_still_running", 64'(sys_start), 64'(1));
    sys_done = 1'b1;
    tick();
    sys_done = 1'b0;
    chk("t6_run_done", 64'(run_done), 64'(1));
    chk("t6_no_timeout", 64'(timeout), 64'(0));
    tick();

    // reset mid-LOAD
    start_run(9'h0C0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 8'hC0;
      in_b = 8'h0C;
      in_last = 1'b0;
      tick();
    end
    chk("t7_pre_count", 64'(load_count), 64'(2));
    reset = 1'b0;
    tick();
    chk("t7_rst_in_ready", 64'(in_ready), 64'(0));
    chk("t7_rst_wren", 64'(ext_wren), 64'(0));
    chk("t7_rst_count", 64'(load_count), 64'(0));
    chk("t7_rst_busy", 64'(busy), 64'(0));
    chk("t7_rst_external", 64'(ext_external), 64'(0));
    chk("t7_rst_bram_sel", 64'(ext_bram_sel), 64'(0));
    chk("t7_rst_addr", 64'(ext_addr), 64'(0));
    chk("t7_rst_wdata", 64'(ext_wdata), 64'(0));
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("t7_idle_in_ready", 64'(in_ready), 64'(0));
    chk("t7_idle_busy", 64'(busy), 64'(0));
    start_run(9'h0E0);
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_last = 1'b1;
    tick();
    chk("t7_addr", 64'(ext_addr), 64'(9'h0E0));
    chk("t7_wdata", 64'(ext_wdata), 64'(40'h0000003412));
    chk("t7_count", 64'(load_count), 64'(1));
    finish_run();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
